// File: rtl/pergate_step_ctrl_if.sv
// pergate_step_ctrl_if: challenge, bank-launch and round-output signals of the per-gate step sequencer
interface pergate_step_ctrl_if #(
  parameter int F_NBITS = 16,
  parameter int SW      = 3
);
  logic               start;
  logic               tau_valid;
  logic [F_NBITS-1:0] tau_in;
  logic [F_NBITS-1:0] m_tau_p1_in;
  logic               tau_ready;
  logic               pg_en;
  logic               pg_restart;
  logic               pg_precomp;
  logic               pg_mux_sel;
  logic [F_NBITS-1:0] pg_tau;
  logic [F_NBITS-1:0] pg_m_tau_p1;
  logic               pg_ready_all;
  logic               out_valid;
  logic [SW-1:0]      out_step;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               err;
  modport master (
    input  start, tau_valid, tau_in, m_tau_p1_in, pg_ready_all, out_ready,
    output tau_ready, pg_en, pg_restart, pg_precomp, pg_mux_sel, pg_tau, pg_m_tau_p1,
           out_valid, out_step, busy, done, err
  );
  modport slave (
    output start, tau_valid, tau_in, m_tau_p1_in, pg_ready_all, out_ready,
    input  tau_ready, pg_en, pg_restart, pg_precomp, pg_mux_sel, pg_tau, pg_m_tau_p1,
           out_valid, out_step, busy, done, err
  );
endinterface

// File: rtl/pergate_step_ctrl.sv
// pergate_step_ctrl: steps a bank of per-gate sumcheck units through every id bit of a layer,
// one upstream challenge per step, presenting round outputs for the input-bit steps.
module pergate_step_ctrl #(
  parameter int NGBITS  = 3,
  parameter int NINBITS = 2,
  parameter int F_NBITS = 16
) (
  input  logic               clk,
  input  logic               rstb,
  pergate_step_ctrl_if.master bus
);
  localparam int NSTEPS = NGBITS - 1 + 2 * NINBITS;
  localparam int NPRE   = NGBITS - 1;
  localparam int SW     = $clog2(NSTEPS + 1);
  localparam logic [SW-1:0] NSTEPS_W = SW'(NSTEPS);
  localparam logic [SW-1:0] NPRE_W   = SW'(NPRE);
  localparam logic [SW-1:0] NMUX_W   = SW'(NPRE + NINBITS);
  typedef enum logic [2:0] {IDLE, GET_TAU, LAUNCH, WAIT_LO, WAIT_HI, PRESENT, FINISH} state_t;
  state_t             state_q;
  logic [SW-1:0]      step_q, step_d, out_step_q;
  logic [1:0]         lo_cnt_q;
  logic [F_NBITS-1:0] tau_q, m_tau_p1_q;
  logic               pg_en_q, pg_restart_q, pg_precomp_q, pg_mux_sel_q;
  logic               out_valid_q, busy_q, done_q, err_q;
  logic               is_pre, step_end;
  assign step_d   = step_q + SW'(1);
  assign is_pre   = step_q < NPRE_W;
  // a bank that never drops ready is treated as finished after four WAIT_LO cycles
  assign step_end = bus.pg_ready_all &&
                    (state_q == WAIT_HI || (state_q == WAIT_LO && lo_cnt_q == 2'd3));
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      step_q       <= '0;
      out_step_q   <= '0;
      lo_cnt_q     <= '0;
      tau_q        <= '0;
      m_tau_p1_q   <= '0;
      pg_en_q      <= 1'b0;
      pg_restart_q <= 1'b0;
      pg_precomp_q <= 1'b0;
      pg_mux_sel_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pg_en_q      <= 1'b0;
      pg_restart_q <= 1'b0;
      pg_precomp_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          step_q  <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= GET_TAU;
        end
        GET_TAU: if (bus.tau_valid) begin
          tau_q      <= bus.tau_in;
          m_tau_p1_q <= bus.m_tau_p1_in;
          state_q    <= LAUNCH;
        end
        LAUNCH: if (bus.pg_ready_all) begin
          pg_en_q      <= 1'b1;
          pg_restart_q <= step_q == '0;
          pg_precomp_q <= is_pre;
          pg_mux_sel_q <= step_q >= NMUX_W;
          lo_cnt_q     <= '0;
          state_q      <= WAIT_LO;
        end
        WAIT_LO: if (!bus.pg_ready_all) state_q <= WAIT_HI;
                 else if (lo_cnt_q == 2'd3) err_q <= 1'b1;
                 else lo_cnt_q <= lo_cnt_q + 2'd1;
        WAIT_HI: ;
        PRESENT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          step_q      <= step_d;
          done_q      <= step_d == NSTEPS_W;
          state_q     <= step_d == NSTEPS_W ? FINISH : GET_TAU;
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (step_end) begin
        if (is_pre) begin
          step_q  <= step_d;
          state_q <= GET_TAU;
        end else begin
          out_valid_q <= 1'b1;
          out_step_q  <= step_q - NPRE_W;
          state_q     <= PRESENT;
        end
      end
    end
  end
  assign bus.tau_ready   = state_q == GET_TAU;
  assign bus.pg_en       = pg_en_q;
  assign bus.pg_restart  = pg_restart_q;
  assign bus.pg_precomp  = pg_precomp_q;
  assign bus.pg_mux_sel  = pg_mux_sel_q;
  assign bus.pg_tau      = tau_q;
  assign bus.pg_m_tau_p1 = m_tau_p1_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_step    = out_step_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_pergate_step_ctrl.sv
// tb_pergate_step_ctrl: random layers checked against a per-step model of the sequencer.
module tb_pergate_step_ctrl;
  localparam int NG = 3, NI = 2, FW = 16;
  localparam int NSTEPS = NG - 1 + 2 * NI;
  localparam int NPRE = NG - 1;
  localparam int SW = $clog2(NSTEPS + 1);
  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;
  pergate_step_ctrl_if #(.F_NBITS(FW), .SW(SW)) bus ();
  pergate_step_ctrl #(.NGBITS(NG), .NINBITS(NI), .F_NBITS(FW)) dut (.clk(clk), .rstb(rstb), .bus(bus));
  int errors = 0, checks = 0;
  logic [FW-1:0] tq[$], mq[$];
  int pulses, hs, dones, cyc, last_acc, bank_cnt, lat, prev_en, pend;
  int hold_step, tv_hold, stall_round, or_stall, tv_pct, or_pct, first_pulse, err_rise;
  bit noise;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {bus.tau_ready, bus.pg_en, bus.pg_restart, bus.pg_precomp, bus.pg_mux_sel,
                          bus.out_valid, bus.busy, bus.done, bus.err}, 0);
    check({tag, "_tau"}, {bus.pg_tau, bus.pg_m_tau_p1}, 0);
    check({tag, "_step"}, 32'(bus.out_step), 0);
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.pg_en) bank_cnt = lat;
    bus.pg_ready_all = bank_cnt == 0;
    if (bank_cnt > 0) bank_cnt--;
    bus.tau_in      = (tq.size() == hold_step) ? 16'h1234 : FW'($urandom);
    bus.m_tau_p1_in = FW'($urandom);
    bus.tau_valid   = (tq.size() == hold_step && tv_hold < 10) ? 1'b0 : ($urandom_range(99) < tv_pct);
    if (bus.tau_ready && !bus.tau_valid && tq.size() == hold_step) tv_hold++;
    bus.out_ready = (bus.out_valid && hs == stall_round && or_stall < 7) ? 1'b0 : ($urandom_range(99) < or_pct);
    if (bus.out_valid && !bus.out_ready && hs == stall_round) or_stall++;
    bus.start = bus.busy && (bus.done || (noise && $urandom_range(7) == 0));
    if (bus.pg_en) begin
      check("pg_en_gap", prev_en, 0);
      check("en_after_accept", tq.size() > pulses, 1);
      if (tq.size() > pulses) begin
        check("pg_tau_launch", bus.pg_tau, tq[pulses]);
        check("pg_m_tau_launch", bus.pg_m_tau_p1, mq[pulses]);
      end
      check("restart", bus.pg_restart, pulses == 0);
      check("precomp", bus.pg_precomp, pulses < NPRE);
      check("mux_sel", bus.pg_mux_sel, pulses >= NPRE + NI);
      if (pulses == 0) first_pulse = cyc;
      pulses++;
    end else if (bus.busy) check("strobe_alone", {bus.pg_restart, bus.pg_precomp}, 0);
    prev_en = bus.pg_en;
    if (bus.busy && pulses > 0) begin
      check("mux_hold", bus.pg_mux_sel, pulses - 1 >= NPRE + NI);
      if (tq.size() == pulses) check("tau_hold", bus.pg_tau, tq[pulses-1]);
    end
    if (pend) check("out_valid_hold", bus.out_valid, 1);
    pend = 0;
    if (bus.out_valid) begin
      check("out_step", 32'(bus.out_step), hs);
      check("quiet_in_present", {bus.tau_ready, bus.pg_en}, 0);
      check("present_after", pulses, NPRE + hs + 1);
      if (bus.out_ready) begin
        hs++;
        last_acc = cyc;
      end else pend = 1;
    end
    if (bus.tau_ready && bus.tau_valid) begin
      tq.push_back(bus.tau_in);
      mq.push_back(bus.m_tau_p1_in);
    end
    if (bus.done) begin
      dones++;
      check("done_latency", cyc - last_acc, 1);
    end
    if (bus.err && err_rise < 0) err_rise = cyc;
  endtask
  task automatic run_layer(input int l, input int tvp, input int orp, input int hstep,
                           input int sround, input bit nz, input bit exp_err, input int abort_pulse);
    int ab = 0;
    tq.delete();
    mq.delete();
    pulses = 0; hs = 0; dones = 0; prev_en = 0; pend = 0; tv_hold = 0; or_stall = 0;
    err_rise = -1; first_pulse = -1; last_acc = -100;
    lat = l; tv_pct = tvp; or_pct = orp; hold_step = hstep; stall_round = sround; noise = nz;
    @(negedge clk);
    cyc++;
    check("idle_before_start", bus.busy, 0);
    bus.start = 1'b1;
    bus.tau_valid = 1'b1;
    tick();
    check("err_clear_on_start", bus.err, 0);
    for (int n = 0; n < 800 && dones == 0; n++) begin
      tick();
      if (abort_pulse >= 0 && pulses == abort_pulse + 1 && ++ab == 2) begin
        rstb = 1'b0;
        #1 check_reset("abort");
        @(negedge clk);
        check_reset("abort_hold");
        rstb = 1'b1;
        bank_cnt = 0;
        repeat (4) tick();
        check("abort_no_done", dones, 0);
        check("abort_idle", bus.busy, 0);
        return;
      end
    end
    check("done_seen", dones, 1);
    check("pulse_count", pulses, NSTEPS);
    check("round_count", hs, 2 * NI);
    check("err_flag", bus.err, exp_err);
    if (exp_err) check("err_timing", err_rise - first_pulse, 4);
    noise = 0;
    repeat (6) tick();
    check("single_done", dones, 1);
    check("no_extra_en", pulses, NSTEPS);
    check("idle_after", bus.busy, 0);
  endtask
  initial begin
    bus.start = 0; bus.tau_valid = 0; bus.tau_in = 0; bus.m_tau_p1_in = 0;
    bus.pg_ready_all = 1; bus.out_ready = 0;
    cyc = 0; bank_cnt = 0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rstb = 1'b1;
    run_layer(5, 100, 100, -1, -1, 0, 0, -1);
    run_layer(5, 100, 100, 3, -1, 0, 0, -1);
    run_layer(5, 100, 100, -1, 1, 0, 0, -1);
    run_layer(0, 100, 100, -1, -1, 0, 1, -1);
    run_layer(5, 100, 100, -1, -1, 0, 0, -1);
    run_layer(5, 100, 100, -1, -1, 0, 0, 2);
    run_layer(5, 100, 100, -1, -1, 1, 0, -1);
    for (int i = 0; i < 6; i++)
      run_layer($urandom_range(1, 6), $urandom_range(30, 100), $urandom_range(30, 100), -1, -1, 1, 0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pergate_step_ctrl.md
# pergate_step_ctrl

Sequencer for one prover layer's bank of per-gate sumcheck compute units. It steps every unit in lock-step through all identifier bits of a layer. The first (gate-bit) steps are precomputation-only; the remaining (input-bit) steps produce round outputs. Each step pulls one random challenge from upstream, launches the bank, waits for the bank to drain, and hands the result downstream through a valid/ready handshake.

## Interface
- NGBITS, 3: gate-id bits per layer; must be ≥ 1.
- NINBITS, 2: bits per input id; must be ≥ 1.
- Derived: NSTEPS = NGBITS-1+2*NINBITS; NPRE = NGBITS-1; SW = clog2(NSTEPS+1).
- clk  in  1  clock.
- rstb  in  1  reset; asynchronous, active-low.
- start  in  1  begin a layer; sampled in IDLE only.
- tau_valid  in  1  challenge available.
- tau_in  in  F_NBITS  challenge value.
- m_tau_p1_in  in  F_NBITS  precomputed 1-tau companion value.
- tau_ready  out  1  challenge accepted this cycle.
- pg_en  out  1  one-cycle launch pulse to all units.
- pg_restart  out  1  high with pg_en on step 0 only.
- pg_precomp  out  1  high with pg_en while step < NPRE.
- pg_mux_sel  out  1  input-select for the bank; 0 while step < NPRE+NINBITS, else 1; registered, stable for the whole step.
- pg_tau, pg_m_tau_p1  out  F_NBITS each  latched challenge; stable from launch until the next accept.
- pg_ready_all  in  1  AND of all unit ready outputs.
- out_valid  out  1  bank outputs valid for a compute step.
- out_step  out  SW  compute-round index 0..2*NINBITS-1.
- out_ready  in  1  downstream consumed outputs.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse after the final step.
- err  out  1  sticky: the bank never dropped ready after a launch.

## Operation
- States: IDLE, GET_TAU, LAUNCH, WAIT_LO, WAIT_HI, PRESENT, FINISH.
- IDLE: on start, step←0 and go to GET_TAU. start is ignored in every other state.
- GET_TAU: tau_ready=1. On tau_valid, latch tau_in and m_tau_p1_in, then go to LAUNCH.
- LAUNCH: requires pg_ready_all=1 (waits otherwise). Then drive pg_en=1 for exactly one cycle, with restart/precomp decoded from step, and go to WAIT_LO.
- WAIT_LO: wait for pg_ready_all=0.
  - If still 1 after 4 cycles: set err, treat the step as complete, and proceed as from WAIT_HI.
- WAIT_HI: wait for pg_ready_all=1.
  - If the step is precomp: step++, go to GET_TAU.
  - Otherwise: go to PRESENT.
- PRESENT: out_valid=1 and out_step=step-NPRE, both held until out_ready.
  - On the accept cycle, step++.
  - If the new step == NSTEPS, go to FINISH; else go to GET_TAU.
- FINISH: done=1 for one cycle, then IDLE.
- err clears only on reset or on start accepted in IDLE.
- The step counter never exceeds NSTEPS. Steps whose index is ≥ NSTEPS are unreachable.

## Timing
- Reset values:
  - state IDLE; step 0.
  - pg_en, pg_restart, pg_precomp, pg_mux_sel: 0.
  - pg_tau, pg_m_tau_p1: 0.
  - tau_ready, out_valid, out_step, busy, done, err: 0.
- Reset asserted mid-layer aborts at once; no done is produced.
- All outputs are registered, except tau_ready, which is a decode of state GET_TAU.
- Minimum per-step overhead, excluding bank latency:
  - 1 cycle accept;
  - 1 cycle launch;
  - 1 cycle to observe ready low;
  - 1 cycle to observe ready high;
  - 1 cycle present, for compute steps only.
- pg_en is never high on two consecutive cycles. The units detect its rising edge.
- tau_valid arriving together with start is not accepted until the following cycle, which is the first GET_TAU cycle.
- out_ready arriving in the same cycle out_valid rises completes the handshake in that cycle.
- done follows the final accept by exactly one cycle.

## Test plan
- NGBITS=3, NINBITS=2, tau always valid, out_ready=1, bank model ready-low for 5 cycles per launch:
  - exactly 6 pg_en pulses;
  - pg_restart only on the first pulse;
  - pg_precomp on pulses 1–2;
  - pg_mux_sel=0 on pulses 1–4, 1 on pulses 5–6;
  - out_step sequence 0,1,2,3;
  - a single done pulse.
- tau_valid withheld 10 cycles before step 3: no pg_en until the accept; pg_tau equals the supplied value (e.g. 0x1234) throughout step 3.
- out_ready held low 7 cycles on compute round 1: out_valid and out_step=1 are stable; no further tau_ready or pg_en until the accept.
- Bank model never drops ready: err=1 after 4 WAIT_LO cycles; the sequence still completes with done; err clears on the next start.
- rstb pulsed low during WAIT_HI of step 2: all outputs return to reset values immediately; a new start replays from step 0 with pg_restart=1.
- start pulsed while busy, and a second start on the done cycle: both ignored; no extra pg_en.
